// File: rtl/csm_mp.sv
// Shared memory for NPORTS processor ports with per-address locking. Each port runs its own
// request FSM; a round-robin arbiter lets one pending port touch memory/locks per cycle.
module csm_mp #(
    parameter int NPORTS = 2,
    parameter int DW     = 8,
    parameter int AW     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NPORTS*DW-1:0] in_AD,
    input  logic [NPORTS-1:0]    rw,
    input  logic [NPORTS-1:0]    enable,
    input  logic [NPORTS-1:0]    hold,
    // The unlock strobe; "release" itself is a reserved word, hence the suffix.
    input  logic [NPORTS-1:0]    release_req,
    output logic [NPORTS-1:0]    ack,
    output logic [2*NPORTS-1:0]  err,
    output logic [NPORTS*DW-1:0] out_data
);
    localparam int DEPTH = 2**AW;
    localparam int IW    = $clog2(NPORTS);
    localparam int PW    = IW + 1;

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_LOCKED = 2'b01;
    localparam logic [1:0] ERR_RANGE  = 2'b10;
    localparam logic [1:0] ERR_PROTO  = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_REQ, ST_RESP} state_e;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_HOLD, OP_RELEASE} op_e;

    state_e        state_q    [NPORTS];
    state_e        state_d    [NPORTS];
    op_e           op_q       [NPORTS];
    op_e           op_d       [NPORTS];
    logic [DW-1:0] addr_q     [NPORTS];
    logic [DW-1:0] addr_d     [NPORTS];
    logic [DW-1:0] wdata_q    [NPORTS];
    logic [DW-1:0] wdata_d    [NPORTS];
    logic [1:0]    err_q      [NPORTS];
    logic [1:0]    err_d      [NPORTS];
    logic [DW-1:0] rdata_q    [NPORTS];
    logic [DW-1:0] rdata_d    [NPORTS];

    logic [DW-1:0] mem_q      [DEPTH];
    logic [DW-1:0] mem_d      [DEPTH];
    logic          lock_vld_q [DEPTH];
    logic          lock_vld_d [DEPTH];
    logic [IW-1:0] lock_own_q [DEPTH];
    logic [IW-1:0] lock_own_d [DEPTH];

    logic [IW-1:0]     rr_q;
    logic [IW-1:0]     rr_d;
    logic              gnt_vld;
    logic [IW-1:0]     gnt_idx;
    logic [NPORTS-1:0] strobe_one;
    logic [NPORTS-1:0] strobe_multi;

    always_comb begin
        strobe_one   = '0;
        strobe_multi = '0;
        for (int p = 0; p < NPORTS; p++) begin
            strobe_multi[p] = (enable[p] & hold[p]) | (enable[p] & release_req[p]) |
                              (hold[p] & release_req[p]);
            strobe_one[p]   = (enable[p] | hold[p] | release_req[p]) & ~strobe_multi[p];
        end
    end

    // Scan from rr_q upward with wrap; iterating backwards lets the nearest candidate win.
    always_comb begin
        logic [PW-1:0] cand;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            cand = {1'b0, rr_q} + PW'(k);
            if (cand >= PW'(NPORTS)) begin
                cand = cand - PW'(NPORTS);
            end
            if (state_q[cand[IW-1:0]] == ST_REQ) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[IW-1:0];
            end
        end
        rr_d = rr_q;
        if (gnt_vld) begin
            rr_d = (gnt_idx == IW'(NPORTS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= '0;
            for (int p = 0; p < NPORTS; p++) begin
                state_q[p] <= ST_IDLE;
                op_q[p]    <= OP_READ;
                addr_q[p]  <= '0;
                wdata_q[p] <= '0;
                err_q[p]   <= ERR_OK;
                rdata_q[p] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i]      <= '0;
                lock_vld_q[i] <= 1'b0;
                lock_own_q[i] <= '0;
            end
        end else begin
            rr_q <= rr_d;
            for (int p = 0; p < NPORTS; p++) begin
                state_q[p] <= state_d[p];
                op_q[p]    <= op_d[p];
                addr_q[p]  <= addr_d[p];
                wdata_q[p] <= wdata_d[p];
                err_q[p]   <= err_d[p];
                rdata_q[p] <= rdata_d[p];
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i]      <= mem_d[i];
                lock_vld_q[i] <= lock_vld_d[i];
                lock_own_q[i] <= lock_own_d[i];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            state_d[p] = state_q[p];
            unique case (state_q[p])
                ST_IDLE: begin
                    if (strobe_one[p]) begin
                        state_d[p] = (enable[p] && rw[p]) ? ST_DATA : ST_REQ;
                    end else if (strobe_multi[p]) begin
                        state_d[p] = ST_RESP;
                    end
                end
                ST_DATA: state_d[p] = ST_REQ;
                ST_REQ: begin
                    if (gnt_vld && (gnt_idx == IW'(p))) begin
                        state_d[p] = ST_RESP;
                    end
                end
                ST_RESP: state_d[p] = ST_IDLE;
                default: state_d[p] = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        logic [DW-1:0] g_addr;
        logic [AW-1:0] g_row;
        logic          g_own;
        logic          g_foreign;
        for (int p = 0; p < NPORTS; p++) begin
            op_d[p]    = op_q[p];
            addr_d[p]  = addr_q[p];
            wdata_d[p] = wdata_q[p];
            err_d[p]   = err_q[p];
            rdata_d[p] = rdata_q[p];
        end
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i]      = mem_q[i];
            lock_vld_d[i] = lock_vld_q[i];
            lock_own_d[i] = lock_own_q[i];
        end

        for (int p = 0; p < NPORTS; p++) begin
            if (state_q[p] == ST_IDLE) begin
                if (strobe_one[p]) begin
                    addr_d[p] = in_AD[p*DW +: DW];
                    if (enable[p]) begin
                        op_d[p] = rw[p] ? OP_WRITE : OP_READ;
                    end else if (hold[p]) begin
                        op_d[p] = OP_HOLD;
                    end else begin
                        op_d[p] = OP_RELEASE;
                    end
                end else if (strobe_multi[p]) begin
                    err_d[p] = ERR_PROTO;
                end
            end
            if (state_q[p] == ST_DATA) begin
                wdata_d[p] = in_AD[p*DW +: DW];
            end
        end

        // Only the granted port touches shared state; range violations win over lock checks.
        g_addr    = addr_q[gnt_idx];
        g_row     = g_addr[AW-1:0];
        g_own     = lock_vld_q[g_row] && (lock_own_q[g_row] == gnt_idx);
        g_foreign = lock_vld_q[g_row] && (lock_own_q[g_row] != gnt_idx);
        if (gnt_vld) begin
            if (g_addr[DW-1:AW] != '0) begin
                err_d[gnt_idx] = ERR_RANGE;
            end else begin
                case (op_q[gnt_idx])
                    OP_READ: begin
                        if (g_foreign) begin
                            err_d[gnt_idx] = ERR_LOCKED;
                        end else begin
                            err_d[gnt_idx]   = ERR_OK;
                            rdata_d[gnt_idx] = mem_q[g_row];
                        end
                    end
                    OP_WRITE: begin
                        if (g_foreign) begin
                            err_d[gnt_idx] = ERR_LOCKED;
                        end else begin
                            err_d[gnt_idx] = ERR_OK;
                            mem_d[g_row]   = wdata_q[gnt_idx];
                        end
                    end
                    OP_HOLD: begin
                        if (g_foreign) begin
                            err_d[gnt_idx] = ERR_LOCKED;
                        end else begin
                            err_d[gnt_idx]    = ERR_OK;
                            lock_vld_d[g_row] = 1'b1;
                            lock_own_d[g_row] = gnt_idx;
                        end
                    end
                    OP_RELEASE: begin
                        if (g_own) begin
                            err_d[gnt_idx]    = ERR_OK;
                            lock_vld_d[g_row] = 1'b0;
                            lock_own_d[g_row] = '0;
                        end else begin
                            err_d[gnt_idx] = ERR_PROTO;
                        end
                    end
                    default: err_d[gnt_idx] = ERR_PROTO;
                endcase
            end
        end
    end

    // Status is only meaningful alongside ack, so err reads zero outside RESP.
    always_comb begin
        logic resp;
        ack      = '0;
        err      = '0;
        out_data = '0;
        resp     = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            resp   = !reset && (state_q[p] == ST_RESP);
            ack[p] = resp;
            if (resp) begin
                err[2*p +: 2] = err_q[p];
            end
            out_data[p*DW +: DW] = rdata_q[p];
        end
    end

endmodule

// File: tb/tb_csm_mp.sv
// Bench for csm_mp (NPORTS=2, DW=8, AW=2): a reference model queues the expected ack cycle,
// status and read data per port at issue time; a negedge monitor retires them on each ack.
module tb_csm_mp;
    localparam int NP     = 2;
    localparam int OP_RD  = 0;
    localparam int OP_WR  = 1;
    localparam int OP_HD  = 2;
    localparam int OP_RL  = 3;
    localparam int OP_BAD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_AD;
    logic [1:0]  rw;
    logic [1:0]  enable;
    logic [1:0]  hold;
    logic [1:0]  release_req;
    logic [1:0]  ack;
    logic [3:0]  err;
    logic [15:0] out_data;

    csm_mp #(.NPORTS(2), .DW(8), .AW(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_AD      (in_AD),
        .rw         (rw),
        .enable     (enable),
        .hold       (hold),
        .release_req(release_req),
        .ack        (ack),
        .err        (err),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] err;
        logic [7:0] data;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] m_mem [4];
    bit         m_lv  [4];
    int         m_own [4];
    logic [7:0] m_rd  [2];
    int         m_rr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            m_mem[i] = 8'h00;
            m_lv[i]  = 1'b0;
            m_own[i] = 0;
        end
        m_rd[0] = 8'h00;
        m_rd[1] = 8'h00;
        m_rr    = 0;
    endtask

    task automatic modelExec(input int p, input int op, input logic [7:0] a,
                             input logic [7:0] d, output logic [1:0] e);
        int r;
        bit foreign;
        r       = int'(a[1:0]);
        foreign = m_lv[r] && (m_own[r] != p);
        if (op == OP_BAD) begin
            e = 2'b11;
        end else if (a > 8'd3) begin
            e = 2'b10;
        end else begin
            case (op)
                OP_RD: if (foreign) e = 2'b01; else begin e = 2'b00; m_rd[p] = m_mem[r]; end
                OP_WR: if (foreign) e = 2'b01; else begin e = 2'b00; m_mem[r] = d; end
                OP_HD: if (foreign) e = 2'b01; else begin e = 2'b00; m_lv[r] = 1'b1; m_own[r] = p; end
                default: begin
                    if (m_lv[r] && m_own[r] == p) begin
                        e = 2'b00;
                        m_lv[r] = 1'b0;
                    end else begin
                        e = 2'b11;
                    end
                end
            endcase
        end
        if (op != OP_BAD) m_rr = (p + 1) % NP;
    endtask

    task automatic pushExp(input int p, input int c, input logic [1:0] e);
        exp_t x;
        x.cyc  = c;
        x.err  = e;
        x.data = m_rd[p];
        if (p == 0) sb0.push_back(x);
        else sb1.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearStrobes();
        enable      = '0;
        hold        = '0;
        release_req = '0;
        rw          = '0;
    endtask

    task automatic driveStrobe(input int p, input int op, input logic [7:0] a);
        in_AD[p*8 +: 8] = a;
        case (op)
            OP_RD: begin enable[p] = 1'b1; rw[p] = 1'b0; end
            OP_WR: begin enable[p] = 1'b1; rw[p] = 1'b1; end
            OP_HD: hold[p] = 1'b1;
            OP_RL: release_req[p] = 1'b1;
            default: begin enable[p] = 1'b1; hold[p] = 1'b1; end
        endcase
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 20; i++) begin
            if (sb0.size() == 0 && sb1.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("drain_pending", sb0.size() + sb1.size(), 0);
        sb0.delete();
        sb1.delete();
        step();
    endtask

    task automatic applyStimulus(input int p, input int op, input logic [7:0] a,
                                 input logic [7:0] d);
        logic [1:0] e;
        int t;
        t = cyc;
        modelExec(p, op, a, d, e);
        pushExp(p, t + ((op == OP_BAD) ? 1 : (op == OP_WR) ? 3 : 2), e);
        driveStrobe(p, op, a);
        step();
        clearStrobes();
        if (op == OP_WR) begin
            in_AD[p*8 +: 8] = d;
            step();
        end
        waitIdle();
    endtask

    task automatic readPair(input logic [7:0] a);
        logic [1:0] e;
        int t, first, second;
        t      = cyc;
        first  = m_rr;
        second = 1 - first;
        modelExec(first, OP_RD, a, 8'h00, e);
        pushExp(first, t + 2, e);
        modelExec(second, OP_RD, a, 8'h00, e);
        pushExp(second, t + 3, e);
        driveStrobe(0, OP_RD, a);
        driveStrobe(1, OP_RD, a);
        step();
        clearStrobes();
        waitIdle();
    endtask

    task automatic writeThenRead(input logic [7:0] a, input logic [7:0] d);
        logic [1:0] e;
        int t;
        t = cyc;
        modelExec(0, OP_WR, a, d, e);
        pushExp(0, t + 3, e);
        modelExec(1, OP_RD, a, 8'h00, e);
        pushExp(1, t + 4, e);
        driveStrobe(0, OP_WR, a);
        step();
        clearStrobes();
        in_AD[7:0] = d;
        step();
        driveStrobe(1, OP_RD, a);
        step();
        clearStrobes();
        waitIdle();
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (!reset) begin
            for (int p = 0; p < NP; p++) begin
                if (ack[p]) begin
                    if ((p == 0 && sb0.size() == 0) || (p == 1 && sb1.size() == 0)) begin
                        checkOutput($sformatf("p%0d_unexpected_ack", p), 32'(ack[p]), 0);
                    end else begin
                        if (p == 0) x = sb0.pop_front();
                        else x = sb1.pop_front();
                        checkOutput($sformatf("p%0d_ack_cycle", p), cyc, x.cyc);
                        checkOutput($sformatf("p%0d_err", p), 32'(err[2*p +: 2]), 32'(x.err));
                        checkOutput($sformatf("p%0d_out_data", p), 32'(out_data[p*8 +: 8]),
                                    32'(x.data));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        in_AD = '0;
        clearStrobes();
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ack", 32'(ack), 0);
        checkOutput("reset_err", 32'(err), 0);
        checkOutput("reset_out_data", 32'(out_data), 0);
        step();
        reset = 1'b0;
        step();

        readPair(8'd2);
        applyStimulus(0, OP_WR, 8'd1, 8'hA5);
        applyStimulus(0, OP_RD, 8'd1, 8'h00);
        readPair(8'd1);

        applyStimulus(0, OP_HD, 8'd3, 8'h00);
        applyStimulus(1, OP_WR, 8'd3, 8'hFF);
        applyStimulus(1, OP_RD, 8'd3, 8'h00);
        applyStimulus(0, OP_RD, 8'd3, 8'h00);
        applyStimulus(0, OP_RL, 8'd3, 8'h00);
        applyStimulus(1, OP_WR, 8'd3, 8'hFF);
        applyStimulus(1, OP_RD, 8'd3, 8'h00);

        applyStimulus(1, OP_RL, 8'd0, 8'h00);
        applyStimulus(0, OP_BAD, 8'd2, 8'h00);
        applyStimulus(0, OP_HD, 8'd2, 8'h00);
        applyStimulus(0, OP_HD, 8'd0, 8'h00);
        applyStimulus(1, OP_RL, 8'd2, 8'h00);
        applyStimulus(1, OP_RD, 8'd0, 8'h00);
        applyStimulus(0, OP_WR, 8'd2, 8'h3C);
        applyStimulus(0, OP_HD, 8'd2, 8'h00);
        applyStimulus(0, OP_RL, 8'd2, 8'h00);
        applyStimulus(0, OP_RL, 8'd0, 8'h00);

        applyStimulus(0, OP_RD, 8'h04, 8'h00);
        applyStimulus(1, OP_WR, 8'h80, 8'h11);

        writeThenRead(8'd0, 8'h5A);

        // Reset lands in the write's data cycle: no ack may follow and the word stays 0.
        driveStrobe(0, OP_WR, 8'd2);
        step();
        clearStrobes();
        in_AD[7:0] = 8'h77;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_ack", 32'(ack), 0);
        checkOutput("post_reset_err", 32'(err), 0);
        checkOutput("post_reset_out_data", 32'(out_data), 0);
        modelReset();
        repeat (5) step();
        applyStimulus(0, OP_RD, 8'd2, 8'h00);

        for (int i = 0; i < 24; i++) begin
            int         p;
            int         op;
            logic [7:0] a;
            logic [7:0] d;
            p  = $urandom_range(0, 1);
            op = $urandom_range(0, 4);
            a  = 8'($urandom_range(0, 5));
            d  = 8'($urandom);
            applyStimulus(p, op, a, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
